// File: rtl/serial_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, unsigned or two's-complement.
// Latency 1..NUM cycles after start (early exit on first differing digit); start is ignored while busy.
module serial_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int NUM = WIDTH / DIGIT;
    localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM - 1);

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt, msb_flip;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic             busy_nxt, done_nxt, eq_nxt, gt_nxt, lt_nxt;

    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
    assign msb_flip = signed_mode ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    // Operands shift left each step so the digit under test always sits at the top.
    assign a_dig = a_q[WIDTH-1 -: DIGIT];
    assign b_dig = b_q[WIDTH-1 -: DIGIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            eq    <= eq_nxt;
            gt    <= gt_nxt;
            lt    <= lt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a_q;
        b_nxt     = b_q;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        eq_nxt    = eq;
        gt_nxt    = gt;
        lt_nxt    = lt;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = a ^ msb_flip;
                    b_nxt     = b ^ msb_flip;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                if (a_dig != b_dig) begin
                    eq_nxt    = 1'b0;
                    gt_nxt    = (a_dig > b_dig);
                    lt_nxt    = (a_dig < b_dig);
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    eq_nxt    = 1'b1;
                    gt_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt  = cnt + CW'(1);
                    a_nxt    = a_q << DIGIT;
                    b_nxt    = b_q << DIGIT;
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    a_result_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0({eq, gt, lt}));
    a_done_not_busy: assert property (@(posedge clk) disable iff (rst) done |-> !busy);

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboarded bench: four comparator configurations driven with directed and random compares.
module tb_serial_mag_comparator;

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   cyc;
    } exp_t;

    localparam int NDUT = 4;
    localparam int W_T [NDUT] = '{16, 8, 8, 8};
    localparam int D_T [NDUT] = '{4, 1, 2, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_v [NDUT];
    logic        sm_v    [NDUT];
    logic [15:0] a_v     [NDUT];
    logic [15:0] b_v     [NDUT];
    logic        busy_v  [NDUT];
    logic        done_v  [NDUT];
    logic        eq_v    [NDUT];
    logic        gt_v    [NDUT];
    logic        lt_v    [NDUT];

    exp_t q [NDUT][$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int got, input int want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: signed/unsigned ordering by integer arithmetic, latency from the first differing digit.
    function automatic exp_t model(input int w, input int d, input logic [15:0] av,
                                   input logic [15:0] bv, input logic sm, input int acc);
        exp_t   e;
        longint one = 1;
        longint mask = (one << w) - 1;
        longint ua = longint'(av) & mask;
        longint ub = longint'(bv) & mask;
        longint sa = ua;
        longint sb = ub;
        longint dm = (one << d) - 1;
        int     lat = w / d;
        if (sm && sa >= (one << (w - 1))) sa = sa - (one << w);
        if (sm && sb >= (one << (w - 1))) sb = sb - (one << w);
        e.eq = (sa == sb);
        e.gt = (sa > sb);
        e.lt = (sa < sb);
        for (int j = 0; j < w / d; j++) begin
            if (((ua >> (w - (j + 1) * d)) & dm) != ((ub >> (w - (j + 1) * d)) & dm)) begin
                lat = j + 1;
                break;
            end
        end
        e.cyc = acc + lat;
        return e;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int W = W_T[g];
        localparam int D = D_T[g];

        serial_mag_comparator #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_v[g]),
            .signed_mode (sm_v[g]),
            .a           (a_v[g][W-1:0]),
            .b           (b_v[g][W-1:0]),
            .busy        (busy_v[g]),
            .done        (done_v[g]),
            .eq          (eq_v[g]),
            .gt          (gt_v[g]),
            .lt          (lt_v[g])
        );

        // Monitor: pops on every done, otherwise checks that results hold.
        initial begin
            logic [2:0] last;
            exp_t       e;
            last = 3'b000;
            forever begin
                @(negedge clk);
                if (rst) begin
                    last = 3'b000;
                end else if (done_v[g]) begin
                    chk($sformatf("dut%0d_done_busy", g), int'(busy_v[g]), 0);
                    if (q[g].size() == 0) begin
                        chk($sformatf("dut%0d_spurious_done", g), 1, 0);
                    end else begin
                        e = q[g].pop_front();
                        chk($sformatf("dut%0d_result", g), int'({eq_v[g], gt_v[g], lt_v[g]}),
                            int'({e.eq, e.gt, e.lt}));
                        chk($sformatf("dut%0d_latency", g), cyc, e.cyc);
                    end
                    last = {eq_v[g], gt_v[g], lt_v[g]};
                end else begin
                    chk($sformatf("dut%0d_hold", g), int'({eq_v[g], gt_v[g], lt_v[g]}), int'(last));
                end
            end
        end
    end

    // Drives one request at a negedge once the DUT is idle; the accepting edge is the next posedge.
    task automatic issue(input int i, input logic [15:0] av, input logic [15:0] bv,
                         input logic smv, input bit push, input bit wait_neg);
        int n = 0;
        if (wait_neg) @(negedge clk);
        while (busy_v[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy_v[i]) chk("idle_timeout", 1, 0);
        a_v[i]     = av;
        b_v[i]     = bv;
        sm_v[i]    = smv;
        start_v[i] = 1'b1;
        if (push) q[i].push_back(model(W_T[i], D_T[i], av, bv, smv, cyc + 1));
        @(posedge clk);
        #1 start_v[i] = 1'b0;
        a_v[i] = 16'($urandom);
        b_v[i] = 16'($urandom);
        sm_v[i] = 1'($urandom);
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (!done_v[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done_v[i]) chk("done_timeout", 1, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) chk("drain", q[i].size(), 0);
    endtask

    task automatic random_run(input int i, input int cnt);
        logic [15:0] av, bv, mask;
        int          w;
        w = W_T[i];
        mask = 16'((32'd1 << w) - 1);
        for (int k = 0; k < cnt; k++) begin
            av = 16'($urandom) & mask;
            case ($urandom_range(0, 2))
                0:       bv = av;
                1:       bv = av ^ 16'(32'd1 << $urandom_range(0, w - 1));
                default: bv = 16'($urandom) & mask;
            endcase
            issue(i, av, bv, 1'($urandom), 1'b1, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            start_v[i] = 1'b0;
            sm_v[i]    = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
        end
        #1 rst = 1'b1;
        #1;
        chk("reset_dut0", int'({busy_v[0], done_v[0], eq_v[0], gt_v[0], lt_v[0]}), 0);
        chk("reset_dut3", int'({busy_v[3], done_v[3], eq_v[3], gt_v[3], lt_v[3]}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases on the 16/4 instance.
        issue(0, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("busy_after_accept", int'(busy_v[0]), 1);
        issue(0, 16'h9000, 16'h1000, 1'b0, 1'b1, 1'b1);
        issue(0, 16'h9000, 16'h1000, 1'b1, 1'b1, 1'b1);
        issue(0, 16'h1235, 16'h1234, 1'b0, 1'b1, 1'b1);
        issue(0, 16'h1200, 16'h1300, 1'b0, 1'b1, 1'b1);
        repeat (6) @(negedge clk);

        // Start while busy is ignored, then a back-to-back request in the done cycle.
        issue(0, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        a_v[0] = 16'hFFFF;
        b_v[0] = 16'h0000;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        @(negedge clk);
        wait_done(0);
        issue(0, 16'h8001, 16'h8001, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b_busy", int'(busy_v[0]), 1);
        drain();

        // Reset mid-compare discards the compare and clears the results.
        issue(0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs", int'({busy_v[0], done_v[0], eq_v[0], gt_v[0], lt_v[0]}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(0, 16'h00F0, 16'h00E0, 1'b0, 1'b1, 1'b1);
        drain();

        random_run(0, 150);
        fork
            random_run(1, 200);
            random_run(2, 200);
            random_run(3, 200);
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
